// File: rtl/pwm_pkg.sv
// ==========================================================================
// pwm_pkg : shared helpers and register reset values for pwm_multi_channel
// Revision : 1.0
// ==========================================================================
`default_nettype none

package pwm_pkg;

   localparam int   RST_CNT  = 0;
   localparam int   RST_DUTY = 0;
   localparam logic RST_INV  = 1'b0;

   // Channel-select width: enough bits to address n channels, never below one.
   function automatic int ch_width(input int n);
      int w;
      w = 0;
      while ((1 << w) < n) w++;
      return (w < 1) ? 1 : w;
   endfunction

endpackage

`default_nettype wire

// File: rtl/pwm_channel.sv
// ==========================================================================
// pwm_channel : shadow/active duty registers, comparator and output flop
// Revision : 1.0
// ==========================================================================
`default_nettype none

module pwm_channel
   import pwm_pkg::*;
#(
   parameter int CNT_W = 16
)(
   input  logic             clk,
   input  logic             reset_n,
   input  logic             enable,
   input  logic [CNT_W-1:0] cnt,
   input  logic             wrap,
   input  logic             wr_stb,
   input  logic [CNT_W-1:0] wr_duty,
   input  logic             wr_invert,
   output logic             pwm
);

   logic [CNT_W-1:0] shadow_duty;
   logic [CNT_W-1:0] active_duty;
   logic             shadow_inv;
   logic             active_inv;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         shadow_duty <= CNT_W'(RST_DUTY);
         active_duty <= CNT_W'(RST_DUTY);
         shadow_inv  <= RST_INV;
         active_inv  <= RST_INV;
         pwm         <= 1'b0;
      end else begin
         if (wr_stb) begin
            shadow_duty <= wr_duty;
            shadow_inv  <= wr_invert;
         end
         // Transparent while stopped so the first enabled period uses fresh values.
         if (!enable || wrap) begin
            active_duty <= shadow_duty;
            active_inv  <= shadow_inv;
         end
         pwm <= enable & ((cnt < active_duty) ^ active_inv);
      end
   end

endmodule

`default_nettype wire

// File: rtl/pwm_multi_channel.sv
// ==========================================================================
// pwm_multi_channel : shared prescaler/period counter driving NUM_CH PWMs
// Revision : 1.0
// ==========================================================================
`default_nettype none

module pwm_multi_channel
   import pwm_pkg::*;
#(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16,
   parameter int PRE_W  = 8,
   parameter int CH_W   = ch_width(NUM_CH)
)(
   input  logic              i_clock,
   input  logic              i_reset_n,
   input  logic              i_enable,
   input  logic [PRE_W-1:0]  i_prescale,
   input  logic [CNT_W-1:0]  i_period,
   input  logic              i_wr_valid,
   input  logic [CH_W-1:0]   i_wr_ch,
   input  logic [CNT_W-1:0]  i_wr_duty,
   input  logic              i_wr_invert,
   output logic              o_wr_ready,
   output logic [NUM_CH-1:0] o_pwm,
   output logic              o_period_tick
);

   logic [PRE_W-1:0] pre;
   logic [CNT_W-1:0] cnt;
   logic             tick;
   logic             wrap;
   logic             wr_accept;

   // >= so a lowered prescale/period takes effect at once instead of overrunning.
   assign tick       = i_enable && (pre >= i_prescale);
   assign wrap       = tick && (cnt >= i_period);
   assign o_wr_ready = i_reset_n && !wrap;
   assign wr_accept  = i_wr_valid && o_wr_ready;

   always_ff @(posedge i_clock) begin
      if (!i_reset_n) begin
         pre           <= PRE_W'(RST_CNT);
         cnt           <= CNT_W'(RST_CNT);
         o_period_tick <= 1'b0;
      end else if (!i_enable) begin
         pre           <= PRE_W'(RST_CNT);
         cnt           <= CNT_W'(RST_CNT);
         o_period_tick <= 1'b0;
      end else begin
         o_period_tick <= wrap;
         if (tick) begin
            pre <= PRE_W'(RST_CNT);
            cnt <= wrap ? CNT_W'(RST_CNT) : cnt + CNT_W'(1);
         end else begin
            pre <= pre + PRE_W'(1);
         end
      end
   end

   generate
      for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
         logic wr_stb;
         assign wr_stb = wr_accept && (i_wr_ch == CH_W'(k));

         pwm_channel #(
            .CNT_W (CNT_W)
         ) u_channel (
            .clk       (i_clock),
            .reset_n   (i_reset_n),
            .enable    (i_enable),
            .cnt       (cnt),
            .wrap      (wrap),
            .wr_stb    (wr_stb),
            .wr_duty   (i_wr_duty),
            .wr_invert (i_wr_invert),
            .pwm       (o_pwm[k])
         );
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
// ==========================================================================
// tb_pwm_multi_channel : scoreboard bench with a cycle-level reference model
// Revision : 1.0
// ==========================================================================
`default_nettype none

module tb_pwm_multi_channel;

   localparam int NCH = 4;
   localparam int CW  = 8;
   localparam int PW  = 8;

   logic           clk = 1'b0;
   logic           rst_n;
   logic           en;
   logic [PW-1:0]  prescale;
   logic [CW-1:0]  period;
   logic           wr_valid;
   logic [1:0]     wr_ch;
   logic [CW-1:0]  wr_duty;
   logic           wr_inv;
   logic           wr_ready;
   logic [NCH-1:0] pwm;
   logic           period_tick;

   pwm_multi_channel #(
      .NUM_CH (NCH),
      .CNT_W  (CW),
      .PRE_W  (PW)
   ) dut (
      .i_clock       (clk),
      .i_reset_n     (rst_n),
      .i_enable      (en),
      .i_prescale    (prescale),
      .i_period      (period),
      .i_wr_valid    (wr_valid),
      .i_wr_ch       (wr_ch),
      .i_wr_duty     (wr_duty),
      .i_wr_invert   (wr_inv),
      .o_wr_ready    (wr_ready),
      .o_pwm         (pwm),
      .o_period_tick (period_tick)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [NCH-1:0] pwm;
      logic           tick;
   } out_t;

   logic rdy_q[$];
   out_t out_q[$];
   int   checks = 0;
   int   errors = 0;

   // Reference model: position inside the period plus pending/current channel settings.
   int m_pre, m_cnt;
   int m_sd[NCH];
   int m_ad[NCH];
   bit m_si[NCH];
   bit m_ai[NCH];

   task automatic model_reset();
      m_pre = 0;
      m_cnt = 0;
      for (int k = 0; k < NCH; k++) begin
         m_sd[k] = 0; m_ad[k] = 0; m_si[k] = 0; m_ai[k] = 0;
      end
   endtask

   task automatic cycle();
      bit   tk, w, rdy;
      out_t e;
      e = '0;
      if (!rst_n) begin
         rdy = 1'b0;
         model_reset();
      end else begin
         tk  = en && (m_pre >= int'(prescale));
         w   = tk && (m_cnt >= int'(period));
         rdy = !w;
         for (int k = 0; k < NCH; k++)
            e.pwm[k] = en && ((m_cnt < m_ad[k]) != m_ai[k]);
         e.tick = w;
         if (!en || w)
            for (int k = 0; k < NCH; k++) begin
               m_ad[k] = m_sd[k];
               m_ai[k] = m_si[k];
            end
         if (wr_valid && rdy && int'(wr_ch) < NCH) begin
            m_sd[wr_ch] = int'(wr_duty);
            m_si[wr_ch] = wr_inv;
         end
         if (!en) begin
            m_pre = 0; m_cnt = 0;
         end else if (tk) begin
            m_pre = 0;
            m_cnt = w ? 0 : m_cnt + 1;
         end else begin
            m_pre = m_pre + 1;
         end
      end
      rdy_q.push_back(rdy);
      out_q.push_back(e);
      @(posedge clk);
      #2;
   endtask

   task automatic idle(input int n);
      wr_valid = 1'b0;
      repeat (n) cycle();
   endtask

   task automatic write(input int ch, input int duty, input bit inv);
      wr_valid = 1'b1;
      wr_ch    = 2'(ch);
      wr_duty  = CW'(duty);
      wr_inv   = inv;
      cycle();
      wr_valid = 1'b0;
   endtask

   // Monitor: ready is checked in the cycle it applies to, registered outputs one cycle later.
   initial begin
      logic r;
      out_t o;
      forever begin
         @(negedge clk);
         if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            checks++;
            if (wr_ready !== r) begin
               errors++;
               $display("FAIL wr_ready t=%0t got=%b exp=%b", $time, wr_ready, r);
            end
         end
         if (out_q.size() >= 2) begin
            o = out_q.pop_front();
            checks++;
            if (pwm !== o.pwm) begin
               errors++;
               $display("FAIL pwm t=%0t got=%b exp=%b", $time, pwm, o.pwm);
            end
            checks++;
            if (period_tick !== o.tick) begin
               errors++;
               $display("FAIL period_tick t=%0t got=%b exp=%b", $time, period_tick, o.tick);
            end
         end
      end
   end

   initial begin
      rst_n = 1'b0; en = 1'b0; prescale = '0; period = '0;
      wr_valid = 1'b0; wr_ch = '0; wr_duty = '0; wr_inv = 1'b0;
      model_reset();
      @(posedge clk);
      #2;
      idle(3);
      rst_n = 1'b1;

      // 5 high / 5 low, tick every 10 clocks
      prescale = 8'd0; period = 8'd9;
      write(0, 5, 0);
      idle(2);
      en = 1'b1;
      idle(45);

      // prescale 2, period 3, inverted duty 2: 6 low / 6 high
      en = 1'b0;
      idle(1);
      prescale = 8'd2; period = 8'd3;
      write(0, 0, 0);
      write(1, 2, 1);
      idle(1);
      en = 1'b1;
      idle(50);

      // duty change mid-period waits for the wrap
      en = 1'b0;
      prescale = 8'd0; period = 8'd9;
      write(1, 0, 0);
      write(2, 3, 0);
      idle(1);
      en = 1'b1;
      idle(13);
      write(2, 8, 0);
      idle(30);

      // continuous write requests across wrap cycles
      for (int i = 0; i < 25; i++) begin
         wr_valid = 1'b1;
         wr_ch    = 2'($urandom);
         wr_duty  = CW'($urandom_range(0, 12));
         wr_inv   = 1'($urandom);
         cycle();
      end
      idle(30);

      // duty 0 and duty beyond period, both polarities, then disabled
      en = 1'b0;
      write(0, 0, 0);
      write(1, 0, 1);
      write(2, 12, 0);
      write(3, 12, 1);
      idle(1);
      en = 1'b1;
      idle(25);
      en = 1'b0;
      idle(5);

      // reset mid-period with a pending shadow write
      en = 1'b1;
      idle(7);
      write(0, 5, 0);
      idle(2);
      rst_n = 1'b0;
      idle(2);
      rst_n = 1'b1;
      idle(25);

      // randomized traffic
      for (int blk = 0; blk < 15; blk++) begin
         prescale = PW'($urandom_range(0, 3));
         period   = CW'($urandom_range(0, 15));
         for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 99) == 0) period = CW'($urandom_range(0, 15));
            if ($urandom_range(0, 59) == 0) en = ~en;
            rst_n    = ($urandom_range(0, 399) != 0);
            wr_valid = ($urandom_range(0, 2) == 0);
            wr_ch    = 2'($urandom);
            wr_duty  = CW'($urandom_range(0, 17));
            wr_inv   = 1'($urandom);
            cycle();
         end
      end
      rst_n = 1'b1;
      idle(3);
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

`default_nettype wire
